fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, sitting directly upstream of the load-use hazard detection unit.
- Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Presents the IF/ID fields, including the rs1/rs2 indices the hazard unit compares against ID/EX rd.
- Obeys PCWrite/IF_ID_Write stalls and EX-stage branch redirects; keeps saturating stall/flush counters.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register. It owns the PC,
// drives a synchronous-read instruction memory with one cycle of read
// latency, and presents the decoded register indices that the downstream
// load-use hazard unit compares against ID/EX rd.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   PCWrite        0 = hold the PC (stall from the hazard unit)
//   IF_ID_Write    0 = hold the IF/ID register (stall from the hazard unit)
//   Branch_Taken   EX-stage redirect request
//   Branch_Target  redirect byte address; the two low bits are ignored
//   imem_addr      instruction-memory read address (combinational)
//   imem_en        instruction-memory read enable
//   imem_rdata     memory word addressed by imem_addr on the previous cycle
//   IF_ID_PC       PC of the instruction held in ID
//   IF_ID_PC4      IF_ID_PC + 4
//   IF_ID_Instr    instruction held in ID
//   IF_ID_Valid    0 = the ID slot holds a bubble
//   IF_ID_rs1      rs1 index of the ID instruction, zero for a bubble
//   IF_ID_rs2      rs2 index of the ID instruction, zero for a bubble
//   stall_count    saturating count of stalled cycles
//   flush_count    saturating count of redirects
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_NUMBER = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCWrite,
  input  logic                  IF_ID_Write,
  input  logic                  Branch_Taken,
  input  logic [ADDR_WIDTH-1:0] Branch_Target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [ADDR_WIDTH-1:0] IF_ID_PC,
  output logic [ADDR_WIDTH-1:0] IF_ID_PC4,
  output logic [DATA_WIDTH-1:0] IF_ID_Instr,
  output logic                  IF_ID_Valid,
  output logic [REG_NUMBER-1:0] IF_ID_rs1,
  output logic [REG_NUMBER-1:0] IF_ID_rs2,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  // addi x0,x0,0 -- the canonical RISC-V NOP used to fill bubbles
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  // r_pc is the address whose data is currently on imem_rdata
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_validQ;
  logic [ADDR_WIDTH-1:0] r_ifIdPc;
  logic [ADDR_WIDTH-1:0] r_ifIdPc4;
  logic [DATA_WIDTH-1:0] r_ifIdInstr;
  logic                  r_ifIdValid;
  logic [CNT_WIDTH-1:0]  r_stallCount;
  logic [CNT_WIDTH-1:0]  r_flushCount;

  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_pcPlus4;
  logic [ADDR_WIDTH-1:0] w_imemAddr;

  // Masking (rather than slicing) keeps every target bit in use while
  // forcing word alignment.
  assign w_target  = Branch_Target & ~ADDR_WIDTH'(3);
  assign w_pcPlus4 = r_pc + ADDR_WIDTH'(4);

  // Next fetch address. A redirect always wins; otherwise the address is
  // held (and re-read) while stalled or during the first cycle after reset,
  // so a stall needs no skid buffer -- the held word simply comes back again.
  always_comb begin
    w_imemAddr = w_pcPlus4;
    if (!rst_n) begin
      w_imemAddr = RESET_PC;
    end else if (Branch_Taken) begin
      w_imemAddr = w_target;
    end else if (!r_validQ || !PCWrite) begin
      w_imemAddr = r_pc;
    end
  end

  // PC tracking: the PC register just follows whatever address was issued
  // to the memory, so it always names the word arriving on imem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_validQ <= 1'b0;
    end else begin
      r_pc     <= w_imemAddr;
      r_validQ <= 1'b1;
    end
  end

  // IF/ID register. On a redirect both the word arriving from memory and
  // the instruction currently in ID are wrong-path, so a bubble is loaded
  // even if the hazard unit asked for a hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ifIdPc    <= '0;
      r_ifIdPc4   <= '0;
      r_ifIdInstr <= NOP_INSTR;
      r_ifIdValid <= 1'b0;
    end else if (Branch_Taken || (IF_ID_Write && !r_validQ)) begin
      r_ifIdPc    <= '0;
      r_ifIdPc4   <= '0;
      r_ifIdInstr <= NOP_INSTR;
      r_ifIdValid <= 1'b0;
    end else if (IF_ID_Write) begin
      r_ifIdPc    <= r_pc;
      r_ifIdPc4   <= w_pcPlus4;
      r_ifIdInstr <= imem_rdata;
      r_ifIdValid <= 1'b1;
    end
  end

  // Performance counters. A stall cycle is only counted when no redirect
  // is happening, since a redirect discards the stalled work anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else if (Branch_Taken) begin
      if (r_flushCount != CNT_MAX) begin
        r_flushCount <= r_flushCount + CNT_WIDTH'(1);
      end
    end else if (r_validQ && !PCWrite) begin
      if (r_stallCount != CNT_MAX) begin
        r_stallCount <= r_stallCount + CNT_WIDTH'(1);
      end
    end
  end

  assign imem_addr   = w_imemAddr;
  assign imem_en     = rst_n;
  assign IF_ID_PC    = r_ifIdPc;
  assign IF_ID_PC4   = r_ifIdPc4;
  assign IF_ID_Instr = r_ifIdInstr;
  assign IF_ID_Valid = r_ifIdValid;
  // Bubbles report x0 so the hazard unit never matches against them
  assign IF_ID_rs1   = r_ifIdValid ? r_ifIdInstr[15 +: REG_NUMBER] : '0;
  assign IF_ID_rs2   = r_ifIdValid ? r_ifIdInstr[20 +: REG_NUMBER] : '0;
  assign stall_count = r_stallCount;
  assign flush_count = r_flushCount;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives two fetch_stage instances with shared control inputs: dut0 uses
// RESET_PC=0 and 16-bit counters, dut1 uses RESET_PC=0xFFFFFFF8 and 4-bit
// counters. Each has its own synchronous-read memory model. Expected values
// are queued with the cycle they belong to and drained after each stimulus.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  typedef enum logic [3:0] {
    F_PC, F_PC4, F_INSTR, F_VALID, F_RS1, F_RS2,
    F_ADDR, F_EN, F_STALL, F_FLUSH
  } fieldT;

  typedef struct {
    int          cyc;
    int          dut;
    fieldT       fld;
    logic [31:0] val;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;

  logic [31:0] imemAddr0, imemAddr1;
  logic        imemEn0, imemEn1;
  logic [31:0] imemRdata0, imemRdata1;
  logic [31:0] ifIdPc0, ifIdPc1, ifIdPc40, ifIdPc41;
  logic [31:0] ifIdInstr0, ifIdInstr1;
  logic        ifIdValid0, ifIdValid1;
  logic [4:0]  rs10, rs11, rs20, rs21;
  logic [15:0] stallCount0, flushCount0;
  logic [3:0]  stallCount1, flushCount1;

  int  cycleNo       = 0;
  int  compareCount  = 0;
  int  mismatchCount = 0;
  expT sbQueue[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUMBER(5),
    .RESET_PC(32'h0000_0000), .CNT_WIDTH(16)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .imem_addr(imemAddr0), .imem_en(imemEn0), .imem_rdata(imemRdata0),
    .IF_ID_PC(ifIdPc0), .IF_ID_PC4(ifIdPc40), .IF_ID_Instr(ifIdInstr0),
    .IF_ID_Valid(ifIdValid0), .IF_ID_rs1(rs10), .IF_ID_rs2(rs20),
    .stall_count(stallCount0), .flush_count(flushCount0)
  );

  fetch_stage #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUMBER(5),
    .RESET_PC(32'hFFFF_FFF8), .CNT_WIDTH(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .imem_addr(imemAddr1), .imem_en(imemEn1), .imem_rdata(imemRdata1),
    .IF_ID_PC(ifIdPc1), .IF_ID_PC4(ifIdPc41), .IF_ID_Instr(ifIdInstr1),
    .IF_ID_Valid(ifIdValid1), .IF_ID_rs1(rs11), .IF_ID_rs2(rs21),
    .stall_count(stallCount1), .flush_count(flushCount1)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: add-then-odd-multiply is a bijection, so every address
  // holds a distinct word with varied rs1/rs2 fields.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a + 32'h1234_5678) * 32'h9E37_79B1;
  endfunction

  // Synchronous-read instruction memories with one cycle of latency
  always @(posedge clk) begin
    if (imemEn0) imemRdata0 <= memWord(imemAddr0);
    if (imemEn1) imemRdata1 <= memWord(imemAddr1);
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] sampleField(input int dut, input fieldT fld);
    logic [31:0] v;
    v = '0;
    if (dut == 0) begin
      case (fld)
        F_PC:    v = ifIdPc0;
        F_PC4:   v = ifIdPc40;
        F_INSTR: v = ifIdInstr0;
        F_VALID: v = 32'(ifIdValid0);
        F_RS1:   v = 32'(rs10);
        F_RS2:   v = 32'(rs20);
        F_ADDR:  v = imemAddr0;
        F_EN:    v = 32'(imemEn0);
        F_STALL: v = 32'(stallCount0);
        F_FLUSH: v = 32'(flushCount0);
        default: v = '0;
      endcase
    end else begin
      case (fld)
        F_PC:    v = ifIdPc1;
        F_PC4:   v = ifIdPc41;
        F_INSTR: v = ifIdInstr1;
        F_VALID: v = 32'(ifIdValid1);
        F_RS1:   v = 32'(rs11);
        F_RS2:   v = 32'(rs21);
        F_ADDR:  v = imemAddr1;
        F_EN:    v = 32'(imemEn1);
        F_STALL: v = 32'(stallCount1);
        F_FLUSH: v = 32'(flushCount1);
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic expectVal(input int k, input int dut, input fieldT fld,
                           input logic [31:0] val);
    expT e;
    e.cyc = k;
    e.dut = dut;
    e.fld = fld;
    e.val = val;
    sbQueue.push_back(e);
  endtask

  // A valid IF/ID entry for the instruction fetched from address pc
  task automatic expectIfId(input int k, input int dut, input logic [31:0] pc);
    logic [31:0] w;
    w = memWord(pc);
    expectVal(k, dut, F_PC,    pc);
    expectVal(k, dut, F_PC4,   pc + 32'd4);
    expectVal(k, dut, F_INSTR, w);
    expectVal(k, dut, F_VALID, 32'd1);
    expectVal(k, dut, F_RS1,   {27'd0, w[19:15]});
    expectVal(k, dut, F_RS2,   {27'd0, w[24:20]});
  endtask

  task automatic expectBubble(input int k, input int dut);
    expectVal(k, dut, F_PC,    32'd0);
    expectVal(k, dut, F_PC4,   32'd0);
    expectVal(k, dut, F_INSTR, NOP);
    expectVal(k, dut, F_VALID, 32'd0);
    expectVal(k, dut, F_RS1,   32'd0);
    expectVal(k, dut, F_RS2,   32'd0);
  endtask

  // Compare every queued expectation that belongs to the current cycle
  task automatic drainScoreboard();
    int i;
    expT e;
    i = 0;
    while (i < sbQueue.size()) begin
      if (sbQueue[i].cyc == cycleNo) begin
        e = sbQueue[i];
        checkOutput($sformatf("c%0d dut%0d %s", e.cyc, e.dut, e.fld.name()),
                    sampleField(e.dut, e.fld), e.val);
        sbQueue.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Drive one cycle's inputs away from the rising edge, then sample
  task automatic applyStimulus(input logic rstN, input logic pcw, input logic ifw,
                               input logic bt, input logic [31:0] tgt);
    @(negedge clk);
    rst_n         = rstN;
    PCWrite       = pcw;
    IF_ID_Write   = ifw;
    Branch_Taken  = bt;
    Branch_Target = tgt;
    cycleNo++;
    #2;
    drainScoreboard();
  endtask

  initial begin
    rst_n         = 1'b0;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    Branch_Taken  = 1'b0;
    Branch_Target = '0;

    // Reset held for two cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    expectBubble(2, 0);
    expectVal(2, 0, F_STALL, 32'd0);
    expectVal(2, 0, F_FLUSH, 32'd0);
    expectVal(2, 0, F_ADDR,  32'h0);
    expectVal(2, 0, F_EN,    32'd0);
    expectVal(2, 1, F_ADDR,  32'hFFFF_FFF8);
    expectVal(2, 1, F_EN,    32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // First cycles after release: address held once, then advances
    expectVal(3, 0, F_ADDR,  32'h0);
    expectVal(3, 0, F_VALID, 32'd0);
    expectVal(3, 0, F_EN,    32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectVal(4, 0, F_ADDR,  32'h4);
    expectVal(4, 0, F_VALID, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Free run: IF_ID_PC walks 0..0x1C
    for (int i = 0; i < 8; i++) begin
      expectIfId(5 + i, 0, 32'(4 * i));
      expectVal(5 + i, 0, F_ADDR, 32'(4 * (i + 2)));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    end

    // Two-cycle stall while IF_ID_PC=0x20
    expectIfId(13, 0, 32'h20);
    expectVal(13, 0, F_ADDR, 32'h24);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    expectIfId(14, 0, 32'h20);
    expectVal(14, 0, F_ADDR,  32'h24);
    expectVal(14, 0, F_STALL, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    expectIfId(15, 0, 32'h20);
    expectVal(15, 0, F_ADDR,  32'h28);
    expectVal(15, 0, F_STALL, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIfId(16, 0, 32'h24);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to unaligned 0x43: fetch 0x40, bubble, then 0x40 in ID
    expectIfId(17, 0, 32'h28);
    expectVal(17, 0, F_ADDR,  32'h40);
    expectVal(17, 0, F_FLUSH, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h43);
    expectBubble(18, 0);
    expectVal(18, 0, F_FLUSH, 32'd1);
    expectVal(18, 0, F_ADDR,  32'h44);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIfId(19, 0, 32'h40);
    expectVal(19, 0, F_ADDR, 32'h48);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a stall request: redirect wins
    expectIfId(20, 0, 32'h44);
    expectVal(20, 0, F_ADDR, 32'h100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
    expectBubble(21, 0);
    expectVal(21, 0, F_FLUSH, 32'd2);
    expectVal(21, 0, F_STALL, 32'd2);
    expectVal(21, 0, F_ADDR,  32'h104);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIfId(22, 0, 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset mid-operation, then wrap-around on dut1
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    expectBubble(24, 0);
    expectVal(24, 0, F_STALL, 32'd0);
    expectVal(24, 0, F_FLUSH, 32'd0);
    expectVal(24, 1, F_ADDR,  32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    expectVal(25, 1, F_ADDR,  32'hFFFF_FFF8);
    expectVal(25, 1, F_VALID, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectVal(26, 1, F_ADDR, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIfId(27, 1, 32'hFFFF_FFF8);
    expectVal(27, 1, F_ADDR, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIfId(28, 1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIfId(29, 1, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // 20-cycle stall: dut1's 4-bit counter saturates at 15
    for (int k = 30; k < 50; k++) begin
      expectIfId(k, 1, 32'h4);
      expectVal(k, 1, F_ADDR,  32'h8);
      expectVal(k, 1, F_STALL, 32'((k - 30) > 15 ? 15 : (k - 30)));
      expectIfId(k, 0, 32'hC);
      expectVal(k, 0, F_STALL, 32'(k - 30));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    // Reset asserted mid-stall
    expectVal(50, 1, F_STALL, 32'd15);
    expectVal(50, 0, F_STALL, 32'd20);
    expectVal(50, 1, F_ADDR,  32'hFFFF_FFF8);
    expectVal(50, 1, F_EN,    32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    expectBubble(51, 0);
    expectBubble(51, 1);
    expectVal(51, 0, F_STALL, 32'd0);
    expectVal(51, 1, F_STALL, 32'd0);
    expectVal(51, 0, F_FLUSH, 32'd0);
    expectVal(51, 0, F_ADDR,  32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Anything still queued was never compared
    foreach (sbQueue[i]) begin
      mismatchCount++;
      $display("[TB] FAIL unreached c%0d dut%0d %s: got none, expected 0x%08h",
               sbQueue[i].cyc, sbQueue[i].dut, sbQueue[i].fld.name(), sbQueue[i].val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
